// File: rtl/uart_rx_fifo_if.sv
// UART receive FIFO port bundle.
// Receiver-side inputs and consumer-side handshake/status.
interface uart_rx_fifo_if #(
  parameter int ADDR_W = 4
);
  logic [7:0]      i_data;
  logic            i_done;
  logic            i_rd_en;
  logic            i_clr_ovf;
  logic [7:0]      o_data;
  logic            o_valid;
  logic            o_full;
  logic [ADDR_W:0] o_count;
  logic            o_overflow;

  modport master (
    output i_data,
    output i_done,
    output i_rd_en,
    output i_clr_ovf,
    input  o_data,
    input  o_valid,
    input  o_full,
    input  o_count,
    input  o_overflow
  );

  modport slave (
    input  i_data,
    input  i_done,
    input  i_rd_en,
    input  i_clr_ovf,
    output o_data,
    output o_valid,
    output o_full,
    output o_count,
    output o_overflow
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// FWFT byte FIFO fed by the UART receiver's done rising edge.
// Sticky overflow, count-based full/empty.
module uart_rx_fifo #(
  parameter int ADDR_W = 4
) (
  input logic           clk,
  input logic           rst,
  uart_rx_fifo_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic              done_q;
  logic              overflow;
  logic              capture;
  logic              pop;
  logic              wr;
  logic              full;
  logic              valid;

  assign full    = (count == FULL_CNT);
  assign valid   = (count != '0);
  assign capture = bus.i_done & ~done_q;
  assign pop     = bus.i_rd_en & valid;
  // A pop frees a slot in the same cycle, so a full FIFO still accepts.
  assign wr      = capture & (~full | pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      done_q   <= 1'b1;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      done_q <= bus.i_done;
      if (wr)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      unique case (1'b1)
        (wr & ~pop): count <= count + 1'b1;
        (pop & ~wr): count <= count - 1'b1;
        default:     count <= count;
      endcase
      if (capture & ~wr)
        overflow <= 1'b1;
      else if (bus.i_clr_ovf)
        overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr & ~rst)
      mem[wr_ptr] <= bus.i_data;
  end

  assign bus.o_data     = mem[rd_ptr];
  assign bus.o_valid    = valid;
  assign bus.o_full     = full;
  assign bus.o_count    = count;
  assign bus.o_overflow = overflow;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo.
// Uses ADDR_W=2 (4 entries) so wrap and full cases are short.
module tb_uart_rx_fifo;
  localparam int AW = 2;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  uart_rx_fifo_if #(.ADDR_W(AW)) bus ();

  uart_rx_fifo #(.ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b,
                      input logic rd,
                      input logic clr);
    bus.i_data = b;
    bus.i_done = 1'b0;
    repeat (3) step();
    bus.i_done    = 1'b1;
    bus.i_rd_en   = rd;
    bus.i_clr_ovf = clr;
    step();
    bus.i_rd_en   = 1'b0;
    bus.i_clr_ovf = 1'b0;
  endtask

  task automatic pop();
    bus.i_rd_en = 1'b1;
    step();
    bus.i_rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.i_done = 1'b1;
    step();
    rst = 1'b0;
    repeat (20) step();
    checks++;
    if (bus.o_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid got %b exp 0", bus.o_valid);
    end
    checks++;
    if (bus.o_count !== 3'd0) begin
      errors++;
      $display("FAIL reset_count got %0d exp 0", bus.o_count);
    end
    checks++;
    if (bus.o_full !== 1'b0 || bus.o_overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got full=%b ovf=%b exp 0 0",
               bus.o_full, bus.o_overflow);
    end
  endtask

  task automatic test_single();
    send(8'hA5, 1'b0, 1'b0);
    checks++;
    if (bus.o_valid !== 1'b1 || bus.o_data !== 8'hA5) begin
      errors++;
      $display("FAIL single_head got v=%b d=%h exp 1 a5",
               bus.o_valid, bus.o_data);
    end
    repeat (5) step();
    checks++;
    if (bus.o_count !== 3'd1) begin
      errors++;
      $display("FAIL single_level got %0d exp 1", bus.o_count);
    end
    pop();
    checks++;
    if (bus.o_valid !== 1'b0 || bus.o_count !== 3'd0) begin
      errors++;
      $display("FAIL single_pop got v=%b c=%0d exp 0 0",
               bus.o_valid, bus.o_count);
    end
    pop();
    checks++;
    if (bus.o_count !== 3'd0 || bus.o_overflow !== 1'b0) begin
      errors++;
      $display("FAIL empty_pop got c=%0d ovf=%b exp 0 0",
               bus.o_count, bus.o_overflow);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp [4];
    exp = '{8'h03, 8'h04, 8'h05, 8'h06};
    for (int i = 1; i <= 4; i++)
      send(8'(i), 1'b0, 1'b0);
    checks++;
    if (bus.o_full !== 1'b1 || bus.o_count !== 3'd4) begin
      errors++;
      $display("FAIL wrap_full got f=%b c=%0d exp 1 4",
               bus.o_full, bus.o_count);
    end
    for (int i = 1; i <= 2; i++) begin
      checks++;
      if (bus.o_data !== 8'(i)) begin
        errors++;
        $display("FAIL wrap_pop%0d got %h exp %h", i, bus.o_data, 8'(i));
      end
      pop();
    end
    send(8'h05, 1'b0, 1'b0);
    send(8'h06, 1'b0, 1'b0);
    checks++;
    if (bus.o_full !== 1'b1) begin
      errors++;
      $display("FAIL wrap_refull got %b exp 1", bus.o_full);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.o_valid !== 1'b1 || bus.o_data !== exp[i]) begin
        errors++;
        $display("FAIL wrap_order%0d got v=%b d=%h exp 1 %h",
                 i, bus.o_valid, bus.o_data, exp[i]);
      end
      pop();
    end
    checks++;
    if (bus.o_valid !== 1'b0 || bus.o_count !== 3'd0) begin
      errors++;
      $display("FAIL wrap_empty got v=%b c=%0d exp 0 0",
               bus.o_valid, bus.o_count);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] exp [4];
    exp = '{8'hAA, 8'hAB, 8'hAC, 8'hAD};
    for (int i = 0; i < 4; i++)
      send(exp[i], 1'b0, 1'b0);
    send(8'hFF, 1'b0, 1'b0);
    checks++;
    if (bus.o_overflow !== 1'b1 || bus.o_count !== 3'd4) begin
      errors++;
      $display("FAIL ovf_set got ovf=%b c=%0d exp 1 4",
               bus.o_overflow, bus.o_count);
    end
    bus.i_clr_ovf = 1'b1;
    step();
    bus.i_clr_ovf = 1'b0;
    checks++;
    if (bus.o_overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clr got %b exp 0", bus.o_overflow);
    end
    send(8'hFE, 1'b0, 1'b1);
    checks++;
    if (bus.o_overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set_wins got %b exp 1", bus.o_overflow);
    end
    bus.i_clr_ovf = 1'b1;
    step();
    bus.i_clr_ovf = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.o_data !== exp[i]) begin
        errors++;
        $display("FAIL ovf_data%0d got %h exp %h", i, bus.o_data, exp[i]);
      end
      pop();
    end
  endtask

  task automatic test_full_pop();
    logic [7:0] exp [4];
    exp = '{8'h22, 8'h33, 8'h44, 8'h77};
    send(8'h11, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      send(exp[i], 1'b0, 1'b0);
    send(8'h77, 1'b1, 1'b0);
    checks++;
    if (bus.o_count !== 3'd4 || bus.o_overflow !== 1'b0) begin
      errors++;
      $display("FAIL fullpop got c=%0d ovf=%b exp 4 0",
               bus.o_count, bus.o_overflow);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.o_data !== exp[i]) begin
        errors++;
        $display("FAIL fullpop_data%0d got %h exp %h",
                 i, bus.o_data, exp[i]);
      end
      pop();
    end
  endtask

  task automatic test_one_pop();
    send(8'h55, 1'b0, 1'b0);
    send(8'h66, 1'b1, 1'b0);
    checks++;
    if (bus.o_valid !== 1'b1 || bus.o_data !== 8'h66 ||
        bus.o_count !== 3'd1) begin
      errors++;
      $display("FAIL onepop got v=%b d=%h c=%0d exp 1 66 1",
               bus.o_valid, bus.o_data, bus.o_count);
    end
    pop();
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 5; i++)
      send(8'hC0 + 8'(i), 1'b0, 1'b0);
    bus.i_data = 8'h99;
    bus.i_done = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    bus.i_done = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (bus.o_valid !== 1'b0 || bus.o_count !== 3'd0 ||
        bus.o_overflow !== 1'b0) begin
      errors++;
      $display("FAIL midrst got v=%b c=%0d ovf=%b exp 0 0 0",
               bus.o_valid, bus.o_count, bus.o_overflow);
    end
    repeat (3) step();
    checks++;
    if (bus.o_count !== 3'd0) begin
      errors++;
      $display("FAIL midrst_lost got %0d exp 0", bus.o_count);
    end
    send(8'h3C, 1'b0, 1'b0);
    checks++;
    if (bus.o_data !== 8'h3C || bus.o_count !== 3'd1) begin
      errors++;
      $display("FAIL midrst_first got d=%h c=%0d exp 3c 1",
               bus.o_data, bus.o_count);
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    bus.i_data    = 8'h00;
    bus.i_done    = 1'b1;
    bus.i_rd_en   = 1'b0;
    bus.i_clr_ovf = 1'b0;
    test_reset();
    test_single();
    test_wrap();
    test_overflow();
    test_full_pop();
    test_one_pop();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
